// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 decryption controller.
package ascon_pack;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      WAIT_AD,
      AD,
      WAIT_CT,
      CT,
      WAIT_FINAL,
      FINAL,
      END
   } type_state_ctrl;

   localparam logic [3:0] ROUND_FIRST_A = 4'h0;
   localparam logic [3:0] ROUND_FIRST_B = 4'h6;
   localparam logic [3:0] ROUND_LAST    = 4'hb;

endpackage

// File: rtl/counter_round.sv
// Loadable, enabled up-counter; used for both the round and block counters.
module counter_round #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load wins over increment so a phase change always starts from a known round.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_decrypt_ctrl.sv
// Moore controller sequencing the ASCON-128 decryption permutation datapath
// through init, one AD block, NB_BLOCKS ciphertext blocks and finalisation.
module fsm_decrypt_ctrl
   import ascon_pack::*;
#(
   parameter int NB_BLOCKS = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic           data_valid_i,
   output logic           sel_mux_perm_o,
   output logic           sel_muxData_perm_o,
   output logic [3:0]     round_o,
   output logic           write_enable_data_o,
   output logic           write_enable_cipher_o,
   output logic           write_enable_tag_o,
   output logic           en_xor_begin_data_o,
   output logic           en_xor_begin_key_o,
   output logic           en_xor_end_lsb_o,
   output logic           en_xor_end_key_o,
   output logic [2:0]     block_idx_o,
   output logic           busy_o,
   output logic           plain_valid_o,
   output logic           end_o,
   output type_state_ctrl state_o
);

   localparam logic [2:0] BLK_LAST = 3'(NB_BLOCKS - 1);

   type_state_ctrl state_q, state_d;
   logic           plain_valid_q, plain_valid_d;
   logic [3:0]     rnd_q;
   logic           rnd_load, rnd_en;
   logic [3:0]     rnd_load_val;
   logic [2:0]     blk_q;
   logic           blk_load, blk_en;

   counter_round #(.W(4)) u_round_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (rnd_load),
      .load_val_i (rnd_load_val),
      .en_i       (rnd_en),
      .cnt_o      (rnd_q)
   );

   counter_round #(.W(3)) u_block_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (blk_load),
      .load_val_i (3'd0),
      .en_i       (blk_en),
      .cnt_o      (blk_q)
   );

   // Handshake: data_valid_i is only looked at in WAIT_* states; one high
   // sample there consumes the word and enters the compute state next cycle.
   always_comb begin
      state_d               = state_q;
      rnd_load              = 1'b0;
      rnd_load_val          = ROUND_FIRST_A;
      rnd_en                = 1'b0;
      blk_load              = 1'b0;
      blk_en                = 1'b0;
      sel_mux_perm_o        = 1'b0;
      sel_muxData_perm_o    = 1'b0;
      write_enable_data_o   = 1'b0;
      write_enable_cipher_o = 1'b0;
      write_enable_tag_o    = 1'b0;
      en_xor_begin_data_o   = 1'b0;
      en_xor_begin_key_o    = 1'b0;
      en_xor_end_lsb_o      = 1'b0;
      en_xor_end_key_o      = 1'b0;
      end_o                 = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d  = INIT;
               rnd_load = 1'b1;
            end
         end
         INIT: begin
            write_enable_data_o = 1'b1;
            sel_mux_perm_o      = (rnd_q != ROUND_FIRST_A);
            en_xor_end_key_o    = (rnd_q == ROUND_LAST);
            if (rnd_q == ROUND_LAST) state_d = WAIT_AD;
            else                     rnd_en  = 1'b1;
         end
         WAIT_AD: begin
            if (data_valid_i) begin
               state_d      = AD;
               rnd_load     = 1'b1;
               rnd_load_val = ROUND_FIRST_B;
            end
         end
         AD: begin
            sel_mux_perm_o      = 1'b1;
            write_enable_data_o = 1'b1;
            en_xor_begin_data_o = (rnd_q == ROUND_FIRST_B);
            en_xor_end_lsb_o    = (rnd_q == ROUND_LAST);
            if (rnd_q == ROUND_LAST) begin
               state_d  = WAIT_CT;
               blk_load = 1'b1;
            end else begin
               rnd_en = 1'b1;
            end
         end
         WAIT_CT: begin
            if (data_valid_i) begin
               state_d      = CT;
               rnd_load     = 1'b1;
               rnd_load_val = ROUND_FIRST_B;
            end
         end
         CT: begin
            sel_mux_perm_o        = 1'b1;
            sel_muxData_perm_o    = 1'b1;
            write_enable_data_o   = 1'b1;
            en_xor_begin_data_o   = (rnd_q == ROUND_FIRST_B);
            write_enable_cipher_o = (rnd_q == ROUND_FIRST_B);
            if (rnd_q == ROUND_LAST) begin
               blk_en  = 1'b1;
               state_d = (blk_q + 3'd1 == BLK_LAST) ? WAIT_FINAL : WAIT_CT;
            end else begin
               rnd_en = 1'b1;
            end
         end
         WAIT_FINAL: begin
            if (data_valid_i) begin
               state_d  = FINAL;
               rnd_load = 1'b1;
            end
         end
         FINAL: begin
            sel_mux_perm_o        = 1'b1;
            sel_muxData_perm_o    = 1'b1;
            write_enable_data_o   = 1'b1;
            en_xor_begin_data_o   = (rnd_q == ROUND_FIRST_A);
            en_xor_begin_key_o    = (rnd_q == ROUND_FIRST_A);
            write_enable_cipher_o = (rnd_q == ROUND_FIRST_A);
            en_xor_end_key_o      = (rnd_q == ROUND_LAST);
            write_enable_tag_o    = (rnd_q == ROUND_LAST);
            if (rnd_q == ROUND_LAST) state_d = END;
            else                     rnd_en  = 1'b1;
         end
         END: begin
            end_o    = 1'b1;
            state_d  = IDLE;
            rnd_load = 1'b1;
            blk_load = 1'b1;
         end
         default: begin
            state_d  = IDLE;
            rnd_load = 1'b1;
            blk_load = 1'b1;
         end
      endcase
   end

   assign plain_valid_d = write_enable_cipher_o;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         plain_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         plain_valid_q <= plain_valid_d;
      end
   end

   assign round_o       = rnd_q;
   assign busy_o        = (state_q != IDLE);
   assign plain_valid_o = plain_valid_q;
   assign state_o       = state_q;
   assign block_idx_o   = (state_q == CT || state_q == WAIT_CT ||
                           state_q == WAIT_FINAL || state_q == FINAL) ? blk_q : 3'd0;

endmodule

// File: tb/tb_fsm_decrypt_ctrl.sv
// Directed, table-driven bench for fsm_decrypt_ctrl (NB_BLOCKS = 4).
module tb_fsm_decrypt_ctrl;
   import ascon_pack::*;

   localparam int PH_INIT  = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_AD    = 2;
   localparam int PH_CT    = 3;
   localparam int PH_FINAL = 4;
   localparam int PH_END   = 5;
   localparam int PH_IDLE  = 6;

   typedef struct {
      logic        start;
      logic        dv;
      logic [18:0] exp;
   } vec_t;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b0;
   logic           start_i = 1'b0;
   logic           data_valid_i = 1'b0;
   logic           sel_mux_perm_o, sel_muxData_perm_o;
   logic [3:0]     round_o;
   logic           write_enable_data_o, write_enable_cipher_o, write_enable_tag_o;
   logic           en_xor_begin_data_o, en_xor_begin_key_o;
   logic           en_xor_end_lsb_o, en_xor_end_key_o;
   logic [2:0]     block_idx_o;
   logic           busy_o, plain_valid_o, end_o;
   type_state_ctrl state_o;

   vec_t tbl[$];
   logic prev_wc;
   int   n_checks = 0;
   int   n_fail = 0;

   fsm_decrypt_ctrl #(.NB_BLOCKS(4)) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .start_i               (start_i),
      .data_valid_i          (data_valid_i),
      .sel_mux_perm_o        (sel_mux_perm_o),
      .sel_muxData_perm_o    (sel_muxData_perm_o),
      .round_o               (round_o),
      .write_enable_data_o   (write_enable_data_o),
      .write_enable_cipher_o (write_enable_cipher_o),
      .write_enable_tag_o    (write_enable_tag_o),
      .en_xor_begin_data_o   (en_xor_begin_data_o),
      .en_xor_begin_key_o    (en_xor_begin_key_o),
      .en_xor_end_lsb_o      (en_xor_end_lsb_o),
      .en_xor_end_key_o      (en_xor_end_key_o),
      .block_idx_o           (block_idx_o),
      .busy_o                (busy_o),
      .plain_valid_o         (plain_valid_o),
      .end_o                 (end_o),
      .state_o               (state_o)
   );

   // Clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   wire [18:0] obs = {sel_mux_perm_o, sel_muxData_perm_o, write_enable_data_o,
                      write_enable_cipher_o, write_enable_tag_o, en_xor_begin_data_o,
                      en_xor_begin_key_o, en_xor_end_lsb_o, en_xor_end_key_o, end_o,
                      plain_valid_o, busy_o, round_o, block_idx_o};

   task automatic check(input string name, input int idx, input logic [18:0] act,
                        input logic [18:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Expected outputs of one cycle, derived from the phase and round.
   task automatic add_step(input int ph, input int r, input int b);
      vec_t v;
      logic smp, smd, wed, wec, wet, xbd, xbk, xel, xek, eo, bsy;
      {smp, smd, wed, wec, wet, xbd, xbk, xel, xek, eo} = '0;
      bsy = (ph != PH_IDLE);
      case (ph)
         PH_INIT: begin
            wed = 1'b1; smp = (r != 0); xek = (r == 11);
         end
         PH_AD: begin
            smp = 1'b1; wed = 1'b1; xbd = (r == 6); xel = (r == 11);
         end
         PH_CT: begin
            smp = 1'b1; smd = 1'b1; wed = 1'b1; xbd = (r == 6); wec = (r == 6);
         end
         PH_FINAL: begin
            smp = 1'b1; smd = 1'b1; wed = 1'b1;
            xbd = (r == 0); xbk = (r == 0); wec = (r == 0);
            xek = (r == 11); wet = (r == 11);
         end
         PH_END: eo = 1'b1;
         default: ;
      endcase
      v.start = 1'b0;
      v.dv    = 1'b1;
      v.exp   = {smp, smd, wed, wec, wet, xbd, xbk, xel, xek, eo, prev_wc, bsy,
                 4'(r), 3'(b)};
      prev_wc = wec;
      tbl.push_back(v);
   endtask

   task automatic build(input int stall, input bit start_all);
      int w;
      tbl.delete();
      prev_wc = 1'b0;
      for (int r = 0; r <= 11; r++) add_step(PH_INIT, r, 0);
      add_step(PH_WAIT, 11, 0);
      for (int r = 6; r <= 11; r++) add_step(PH_AD, r, 0);
      w = tbl.size();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < ((b == 0) ? 1 + stall : 1); k++) add_step(PH_WAIT, 11, b);
         for (int r = 6; r <= 11; r++) add_step(PH_CT, r, b);
      end
      add_step(PH_WAIT, 11, 3);
      for (int r = 0; r <= 11; r++) add_step(PH_FINAL, r, 3);
      add_step(PH_END, 11, 0);
      add_step(PH_IDLE, 0, 0);
      tbl[0].start = 1'b1;
      if (start_all) begin
         for (int i = 0; i < tbl.size() - 1; i++) tbl[i].start = 1'b1;
      end
      for (int i = 1; i <= stall; i++) tbl[w + i].dv = 1'b0;
   endtask

   // Driver: vector i's inputs are sampled by the edge that produces cycle i+1.
   task automatic run_table(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         start_i      = tbl[i].start;
         data_valid_i = tbl[i].dv;
         @(posedge clk_i);
         #1;
         check(name, i, obs, tbl[i].exp);
      end
      start_i      = 1'b0;
      data_valid_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_held", 0, obs, 19'h0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("idle_after_reset", 0, obs, 19'h0);

      // Nominal run: end_o at table index 53 = cycle 54 after the start sample.
      build(0, 1'b0);
      if (tbl.size() != 55) begin
         n_checks++; n_fail++;
         $display("FAIL table_len: got %0d expected 55", tbl.size());
      end
      run_table("nominal", tbl.size());

      build(5, 1'b0);
      run_table("stall_ct", tbl.size());

      build(0, 1'b1);
      run_table("start_ignored", tbl.size());

      // Abort in CT round 8 (index 22 = cycle 23), then restart from scratch.
      build(0, 1'b0);
      run_table("pre_abort", 23);
      #2;
      rst_i = 1'b0;
      #1;
      check("abort_same_cycle", 0, obs, 19'h0);
      @(posedge clk_i);
      #1;
      check("abort_held", 0, obs, 19'h0);
      @(negedge clk_i);
      rst_i = 1'b1;
      run_table("restart", tbl.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
